// File: rtl/switch_pkg.sv
// Shared types and constants for the switch-lock controller.
package switch_pkg;

   typedef enum logic [1:0] {
      SW_IDLE      = 2'd0,
      SW_LONG_LOCK = 2'd1,
      SW_SHORT2    = 2'd2,
      SW_DONE      = 2'd3
   } sw_state_e;

   localparam int unsigned SW_LONG_LIMIT  = 10;
   localparam int unsigned SW_SHORT_LIMIT = 2;

   localparam logic [1:0] SW_POS_WRAP_FROM = 2'b11;
   localparam logic [1:0] SW_POS_WRAP_TO   = 2'b00;

endpackage : switch_pkg

// File: rtl/switch_lock_ctrl_if.sv
// Request/lock handshake between the requester and the switch-lock controller.
interface switch_lock_ctrl_if;

   logic       switch_enb;
   logic [1:0] switch_select;
   logic       lock_ack;
   logic       lock_enb;
   logic       done;
   logic       busy;
   logic       timeout;
   logic [1:0] sel_latched;
   logic       req_drop;

   modport master (
      output switch_enb, switch_select, lock_ack,
      input  lock_enb, done, busy, timeout, sel_latched, req_drop
   );

   modport slave (
      input  switch_enb, switch_select, lock_ack,
      output lock_enb, done, busy, timeout, sel_latched, req_drop
   );

endinterface : switch_lock_ctrl_if

// File: rtl/switch_wrap_det.sv
// Detects a 2'b11 -> 2'b00 wrap of the requested switch position.
module switch_wrap_det
   import switch_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] switch_select,
   output logic       wrap
);

   logic [1:0] prev_sel_q;
   logic [1:0] prev_sel_d;

   // Previous position follows the input every cycle.
   always_comb begin
      prev_sel_d = switch_select;
   end

   // Previous-position register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_sel_q <= 2'b00;
      else          prev_sel_q <= prev_sel_d;
   end

   assign wrap = (switch_select == SW_POS_WRAP_TO) && (prev_sel_q == SW_POS_WRAP_FROM);

endmodule : switch_wrap_det

// File: rtl/switch_lock_ctrl.sv
// Switch-lock controller: sequences lock_enb and done for each accepted request.
module switch_lock_ctrl
   import switch_pkg::*;
#(
   parameter int unsigned LONG_MAX  = 10,
   parameter int unsigned SHORT_MAX = 2
)(
   input  logic               clk,
   input  logic               reset_n,
   switch_lock_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = 4;

   // Elaboration-time parameter range checks.
   if (LONG_MAX < 1 || LONG_MAX > SW_LONG_LIMIT) begin : g_bad_long_max
      $error("LONG_MAX out of range");
   end
   if (SHORT_MAX < 1 || SHORT_MAX > SW_SHORT_LIMIT) begin : g_bad_short_max
      $error("SHORT_MAX out of range");
   end

   sw_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_latched_q, sel_latched_d;
   logic             timeout_pend_q, timeout_pend_d;

   logic             wrap;
   logic [CNT_W-1:0] cnt_inc;
   logic             long_last;
   logic             lock_enb_c;
   logic             req_drop_c;

   switch_wrap_det u_wrap_det (
      .clk           (clk),
      .reset_n       (reset_n),
      .switch_select (bus.switch_select),
      .wrap          (wrap)
   );

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign long_last = (cnt_inc == CNT_W'(LONG_MAX));

   // Next-state, counter and Mealy output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      sel_latched_d  = sel_latched_q;
      timeout_pend_d = timeout_pend_q;
      lock_enb_c     = 1'b0;
      req_drop_c     = 1'b0;

      unique case (state_q)
         SW_IDLE: begin
            if (bus.switch_enb) begin
               sel_latched_d = bus.switch_select;
               if (wrap) begin
                  cnt_d   = '0;
                  state_d = SW_LONG_LOCK;
               end else begin
                  // Short path locks in the acceptance cycle itself.
                  lock_enb_c = 1'b1;
                  if (bus.lock_ack || SHORT_MAX == 1) state_d = SW_DONE;
                  else                                state_d = SW_SHORT2;
               end
            end
         end
         SW_SHORT2: begin
            lock_enb_c = 1'b1;
            req_drop_c = bus.switch_enb;
            state_d    = SW_DONE;
         end
         SW_LONG_LOCK: begin
            lock_enb_c = 1'b1;
            req_drop_c = bus.switch_enb;
            if (bus.lock_ack || long_last) begin
               // Counter holds on exit so it never reaches LONG_MAX.
               state_d = SW_DONE;
               if (!bus.lock_ack) timeout_pend_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SW_DONE: begin
            req_drop_c     = bus.switch_enb;
            timeout_pend_d = 1'b0;
            state_d        = SW_IDLE;
         end
         default: state_d = SW_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= SW_IDLE;
         cnt_q          <= '0;
         sel_latched_q  <= 2'b00;
         timeout_pend_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sel_latched_q  <= sel_latched_d;
         timeout_pend_q <= timeout_pend_d;
      end
   end

   assign bus.lock_enb    = lock_enb_c;
   assign bus.req_drop    = req_drop_c;
   assign bus.done        = (state_q == SW_DONE);
   assign bus.timeout     = (state_q == SW_DONE) && timeout_pend_q;
   assign bus.busy        = (state_q != SW_IDLE);
   assign bus.sel_latched = sel_latched_q;

endmodule : switch_lock_ctrl

// File: tb/tb_switch_lock_ctrl.sv
// Directed self-checking bench for switch_lock_ctrl.
module tb_switch_lock_ctrl;

   logic clk;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   switch_lock_ctrl_if bus ();

   switch_lock_ctrl #(.LONG_MAX(10), .SHORT_MAX(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic enb, input logic [1:0] sel, input logic ack);
      bus.switch_enb    = enb;
      bus.switch_select = sel;
      bus.lock_ack      = ack;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1'b0, 2'b00, 1'b0);
      repeat (2) tick();
      @(negedge clk);
      tests_run++;
      if ({bus.lock_enb, bus.done, bus.busy, bus.timeout, bus.req_drop} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL reset_outputs got %b exp 00000",
                  {bus.lock_enb, bus.done, bus.busy, bus.timeout, bus.req_drop});
      end
      tests_run++;
      if (bus.sel_latched !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_sel_latched got %b exp 00", bus.sel_latched);
      end
      tick();
      reset_n = 1'b1;
      // Stray ack while idle must not lock.
      drive(1'b0, 2'b00, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_ack got lock=%b busy=%b exp 0 0", bus.lock_enb, bus.busy);
      end
   endtask

   task automatic test_short_one();
      tick(); drive(1'b1, 2'b01, 1'b1);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL short1_t got lock=%b busy=%b done=%b exp 1 0 0", bus.lock_enb, bus.busy, bus.done);
      end
      tick(); drive(1'b0, 2'b01, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.sel_latched !== 2'b01) begin
         tests_failed++;
         $display("FAIL short1_t1 got lock=%b done=%b busy=%b sel=%b exp 0 1 1 01",
                  bus.lock_enb, bus.done, bus.busy, bus.sel_latched);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL short1_t2 got done=%b busy=%b exp 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_short_two();
      tick(); drive(1'b1, 2'b10, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b1) begin
         tests_failed++;
         $display("FAIL short2_t got lock=%b exp 1", bus.lock_enb);
      end
      tick(); drive(1'b0, 2'b10, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL short2_t1 got lock=%b done=%b busy=%b exp 1 0 1", bus.lock_enb, bus.done, bus.busy);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b0 || bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.sel_latched !== 2'b10) begin
         tests_failed++;
         $display("FAIL short2_t2 got lock=%b done=%b timeout=%b sel=%b exp 0 1 0 10",
                  bus.lock_enb, bus.done, bus.timeout, bus.sel_latched);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL short2_idle got busy=%b exp 0", bus.busy);
      end
   endtask

   task automatic test_long_ack();
      tick(); drive(1'b0, 2'b11, 1'b0);
      tick(); drive(1'b1, 2'b00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL longack_t got lock=%b busy=%b exp 0 0", bus.lock_enb, bus.busy);
      end
      for (int k = 1; k <= 4; k++) begin
         tick(); drive(1'b0, 2'b00, (k == 4) ? 1'b1 : 1'b0);
         @(negedge clk);
         tests_run++;
         if (bus.lock_enb !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL longack_lock%0d got lock=%b done=%b exp 1 0", k, bus.lock_enb, bus.done);
         end
      end
      tick(); drive(1'b0, 2'b00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.lock_enb !== 1'b0 || bus.sel_latched !== 2'b00) begin
         tests_failed++;
         $display("FAIL longack_done got done=%b timeout=%b lock=%b sel=%b exp 1 0 0 00",
                  bus.done, bus.timeout, bus.lock_enb, bus.sel_latched);
      end
      tick();
   endtask

   task automatic test_long_timeout();
      tick(); drive(1'b0, 2'b11, 1'b0);
      tick(); drive(1'b1, 2'b00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b0) begin
         tests_failed++;
         $display("FAIL longto_t got lock=%b exp 0", bus.lock_enb);
      end
      for (int k = 1; k <= 10; k++) begin
         tick(); drive(1'b0, 2'b00, 1'b0);
         @(negedge clk);
         tests_run++;
         if (bus.lock_enb !== 1'b1 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL longto_lock%0d got lock=%b done=%b timeout=%b exp 1 0 0",
                     k, bus.lock_enb, bus.done, bus.timeout);
         end
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.lock_enb !== 1'b0) begin
         tests_failed++;
         $display("FAIL longto_done got done=%b timeout=%b lock=%b exp 1 1 0", bus.done, bus.timeout, bus.lock_enb);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL longto_after got done=%b timeout=%b busy=%b exp 0 0 0", bus.done, bus.timeout, bus.busy);
      end
   endtask

   task automatic test_back_to_back_drop();
      tick(); drive(1'b0, 2'b11, 1'b0);
      tick(); drive(1'b1, 2'b00, 1'b0);
      tick(); drive(1'b0, 2'b00, 1'b0);
      tick(); drive(1'b1, 2'b01, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.req_drop !== 1'b1 || bus.busy !== 1'b1 || bus.lock_enb !== 1'b1) begin
         tests_failed++;
         $display("FAIL drop_long got drop=%b busy=%b lock=%b exp 1 1 1", bus.req_drop, bus.busy, bus.lock_enb);
      end
      tick(); drive(1'b0, 2'b01, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.req_drop !== 1'b0 || bus.sel_latched !== 2'b00) begin
         tests_failed++;
         $display("FAIL drop_after got drop=%b sel=%b exp 0 00", bus.req_drop, bus.sel_latched);
      end
      // Now at t+3; run through t+10 with lock held.
      for (int k = 4; k <= 10; k++) begin
         tick();
         @(negedge clk);
         tests_run++;
         if (bus.lock_enb !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_lock%0d got lock=%b done=%b exp 1 0", k, bus.lock_enb, bus.done);
         end
      end
      // Request during DONE is dropped too and not accepted afterwards.
      tick(); drive(1'b1, 2'b10, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.req_drop !== 1'b1 || bus.sel_latched !== 2'b00) begin
         tests_failed++;
         $display("FAIL drop_done got done=%b timeout=%b drop=%b sel=%b exp 1 1 1 00",
                  bus.done, bus.timeout, bus.req_drop, bus.sel_latched);
      end
      tick(); drive(1'b0, 2'b10, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b0 || bus.lock_enb !== 1'b0 || bus.sel_latched !== 2'b00) begin
         tests_failed++;
         $display("FAIL drop_idle got busy=%b lock=%b sel=%b exp 0 0 00", bus.busy, bus.lock_enb, bus.sel_latched);
      end
   endtask

   task automatic test_reset_mid();
      tick(); drive(1'b0, 2'b11, 1'b0);
      tick(); drive(1'b1, 2'b00, 1'b0);
      tick(); drive(1'b0, 2'b00, 1'b0);
      tick();
      tick();
      // Cycle t+3: assert reset asynchronously mid-cycle.
      reset_n = 1'b0;
      drive(1'b0, 2'b11, 1'b0);
      #1;
      tests_run++;
      if ({bus.lock_enb, bus.done, bus.busy, bus.timeout, bus.req_drop} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL rstmid_async got %b exp 00000",
                  {bus.lock_enb, bus.done, bus.busy, bus.timeout, bus.req_drop});
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         @(negedge clk);
         tests_run++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_hold%0d got done=%b busy=%b exp 0 0", k, bus.done, bus.busy);
         end
      end
      tick();
      reset_n = 1'b1;
      drive(1'b1, 2'b00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b1 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_short got lock=%b busy=%b exp 1 0", bus.lock_enb, bus.busy);
      end
      tick(); drive(1'b0, 2'b00, 1'b0);
      @(negedge clk);
      tests_run++;
      if (bus.lock_enb !== 1'b1 || bus.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_short2 got lock=%b done=%b exp 1 0", bus.lock_enb, bus.done);
      end
      tick();
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.sel_latched !== 2'b00) begin
         tests_failed++;
         $display("FAIL rstmid_done got done=%b timeout=%b sel=%b exp 1 0 00", bus.done, bus.timeout, bus.sel_latched);
      end
      tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_short_one();
      test_short_two();
      test_long_ack();
      test_long_timeout();
      test_back_to_back_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_switch_lock_ctrl
